// File: rtl/mult_unit.sv
// Iterative shift-add multiplier with HI/LO; signed mult only when MULT_SIGNED_EN is defined.
// Result in hi/lo with done one cycle, WIDTH+1 edges after start; busy stalls the datapath, starts while busy are dropped.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mult_we,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic                 r_neg;
   logic [2*WIDTH:0]     r_acc;
   logic [CW-1:0]        r_cnt;

   logic                 w_start;
   logic                 w_step;
   logic                 w_finish;
   logic [WIDTH:0]       w_upper;
   logic [2*WIDTH:0]     w_acc_nxt;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic                 w_neg;
   logic [2*WIDTH-1:0]   w_res;

`ifdef MULT_SIGNED_EN
   assign w_mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign w_mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
   assign w_neg   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
   assign w_res   = r_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
`else
   logic w_unused_sign;
   assign w_unused_sign = is_signed ^ r_neg;
   assign w_mag_a = a;
   assign w_mag_b = b;
   assign w_neg   = 1'b0;
   assign w_res   = r_acc[2*WIDTH-1:0];
`endif

   assign w_start  = (r_state == S_IDLE) && mult_we;
   assign w_step   = (r_state == S_RUN) && (r_cnt != '0);
   assign w_finish = (r_state == S_RUN) && (r_cnt == '0);

   // Carry out of the add lands in the spare top bit, so the shift never loses it.
   assign w_upper   = r_acc[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_nxt = {1'b0, w_upper, r_acc[WIDTH-1:1]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (mult_we) w_next = S_RUN;
         S_RUN:   if (r_cnt == '0) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
         end
         if (w_step) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
         end
         if (w_finish) begin
            hi <= w_res[2*WIDTH-1:WIDTH];
            lo <= w_res[WIDTH-1:0];
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit; expectations switch with MULT_SIGNED_EN.
module tb_mult_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         mult_we = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_err = 0;

`ifdef MULT_SIGNED_EN
   localparam logic [63:0] E_FF_S = 64'h00000000_00000001;
   localparam logic [63:0] E_M3x7 = 64'hFFFFFFFF_FFFFFFEB;
   localparam logic [63:0] E_M5M6 = 64'h00000000_0000001E;
`else
   localparam logic [63:0] E_FF_S = 64'hFFFFFFFE_00000001;
   localparam logic [63:0] E_M3x7 = 64'h00000006_FFFFFFEB;
   localparam logic [63:0] E_M5M6 = 64'hFFFFFFF5_0000001E;
`endif

   mult_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mult_we   (mult_we),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start one product, watch busy/done each cycle, optionally poke mult_we again at cycle inj.
   task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic ts, input int inj, input logic [63:0] exp);
      int cyc, busy_cyc, done_cnt, lat;
      bit timed_out;
      @(negedge clk);
      a = ta; b = tb; is_signed = ts; mult_we = 1'b1;
      @(posedge clk); #1;
      mult_we = 1'b0; a = ~ta; b = ta ^ tb; is_signed = ~ts;
      cyc = 0; busy_cyc = 0; done_cnt = 0; lat = -1; timed_out = 0;
      forever begin
         if (inj >= 0 && cyc == inj) begin
            a = 32'd9; b = 32'd9; mult_we = 1'b1;
         end else begin
            mult_we = 1'b0;
         end
         if (done) begin
            done_cnt++;
            lat = cyc;
         end
         if (!busy) break;
         busy_cyc++;
         if (cyc >= 100) begin
            timed_out = 1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      mult_we = 1'b0;
      chk({tag, ".timeout"}, 64'(timed_out), 64'd0);
      chk({tag, ".busy_cycles"}, 64'(busy_cyc), 64'd34);
      chk({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, ".done_latency"}, 64'(lat), 64'd33);
      chk({tag, ".product"}, {hi, lo}, exp);
      @(posedge clk); #1;
      chk({tag, ".idle_after"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int viol;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset.hi", 64'(hi), 64'd0);
      chk("reset.lo", 64'(lo), 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run("u3x5", 32'd3, 32'd5, 1'b0, -1, 64'h0000000F);

      viol = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (hi !== '0 || lo !== 32'd15 || busy !== 1'b0 || done !== 1'b0) viol++;
      end
      chk("idle_hold.violations", 64'(viol), 64'd0);

      run("uFFxFF", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 64'hFFFFFFFE_00000001);
      run("sFFxFF", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, -1, E_FF_S);
      run("sM3x7", 32'hFFFFFFFD, 32'd7, 1'b1, -1, E_M3x7);
      run("sM5xM6", 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, -1, E_M5M6);
      run("sMinxMin", 32'h80000000, 32'h80000000, 1'b1, -1, 64'h40000000_00000000);
      run("zero", 32'd0, 32'd12345, 1'b0, -1, 64'd0);
      run("restart_run", 32'd2, 32'd2, 1'b0, 10, 64'd4);
      run("restart_fin", 32'd3, 32'd5, 1'b0, 33, 64'd15);

      @(negedge clk);
      a = 32'd4; b = 32'd4; is_signed = 1'b0; mult_we = 1'b1;
      @(posedge clk); #1;
      mult_we = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst.busy", 64'(busy), 64'd0);
      chk("mid_rst.done", 64'(done), 64'd0);
      chk("mid_rst.hi", 64'(hi), 64'd0);
      chk("mid_rst.lo", 64'(lo), 64'd0);

      run("post_rst", 32'd4, 32'd4, 1'b0, -1, 64'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
